// File: rtl/fifo_byte_ptr_ctrl.sv
// fifo_byte_ptr_ctrl: byte/long pointers and INCFIFO/DECFIFO pulses
// Optional macro FIFO_WORD_XFER_EN adds 16-bit WORD_STB transfers
module fifo_byte_ptr_ctrl #(
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RST_FIFO_,
  input  logic             DMADIR,
  input  logic             BYTE_STB,
`ifdef FIFO_WORD_XFER_EN
  input  logic             WORD_STB,
`endif
  input  logic             LONG_STB,
  input  logic             FLUSH,
  input  logic             FIFOFULL,
  input  logic             FIFOEMPTY,
  output logic             INCFIFO,
  output logic             DECFIFO,
  output logic [PTR_W-1:0] WRITE_PTR,
  output logic [PTR_W-1:0] READ_PTR,
  output logic [1:0]       BO,
  output logic [3:0]       BYTE_LANE,
  output logic             BYTE_RDY,
  output logic             LONG_RDY,
  output logic             FLUSHED,
  output logic             OVR
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic       inc_pend;
  logic       dec_pend;
  logic       flush_pend;
  logic       flush_wait;
  logic       dir_q;

  logic       inc_blk;
  logic       dec_blk;
  logic       in_rdy;
  logic       out_rdy;
  logic       word_stb;
  logic       byte_acc;
  logic       word_acc;
  logic       word_bad;
  logic       side_acc;
  logic       side_wrap;
  logic       long_acc;
  logic [1:0] bo_nxt;
  logic       flush_req;
  logic       flush_go;
  logic       flush_inc;
  logic       inc_new;
  logic       dec_new;
  logic       inc_req;
  logic       dec_req;
  logic       idle;
  logic       go_inc;
  logic       go_dec;
  logic       dir_bad;
  logic       ovr_set;

`ifdef FIFO_WORD_XFER_EN
  assign word_stb = WORD_STB;
`else
  assign word_stb = 1'b0;
`endif

  assign inc_blk = inc_pend | INCFIFO;
  assign dec_blk = dec_pend | DECFIFO;
  assign in_rdy  = ~FIFOFULL & ~inc_blk;
  assign out_rdy = ~FIFOEMPTY & ~dec_blk;

  assign BYTE_RDY = DMADIR ? out_rdy : in_rdy;
  assign LONG_RDY = DMADIR ? in_rdy : out_rdy;

  assign byte_acc = BYTE_STB & BYTE_RDY & ~word_stb;
  assign word_acc = word_stb & BYTE_RDY & ~BO[0]
                  & ~BYTE_STB;
  assign word_bad = word_stb
                  & (~BYTE_RDY | BO[0] | BYTE_STB);
  assign side_acc = byte_acc | word_acc;
  assign long_acc = LONG_STB & LONG_RDY;

  assign bo_nxt    = BO + (word_acc ? 2'd2 : 2'd1);
  assign side_wrap = side_acc & (bo_nxt == 2'd0);

  assign flush_req = (FLUSH | flush_pend) & ~DMADIR;
  assign flush_go  = flush_req & ~inc_blk & ~side_acc;
  assign flush_inc = flush_go & (BO != 2'd0);

  assign inc_new = DMADIR ? long_acc
                          : (side_wrap | flush_inc);
  assign dec_new = DMADIR ? side_wrap : long_acc;

  assign inc_req = inc_pend | inc_new;
  assign dec_req = dec_pend | dec_new;
  assign idle    = ~INCFIFO & ~DECFIFO;
  assign go_inc  = idle & inc_req
                 & ~(dec_pend & ~inc_pend);
  assign go_dec  = idle & dec_req & ~go_inc;

  assign dir_bad = (DMADIR != dir_q)
                 & ((BO != 2'd0) | inc_pend | dec_pend);
  assign ovr_set = (BYTE_STB & ~BYTE_RDY & ~word_stb)
                 | (LONG_STB & ~LONG_RDY)
                 | word_bad
                 | dir_bad;

  // lane of the byte or word moved this cycle
  always_comb begin
    BYTE_LANE = 4'b0000;
    unique case (1'b1)
      byte_acc: BYTE_LANE = 4'b1000 >> BO;
      word_acc: BYTE_LANE = 4'b1100 >> BO;
      default:  BYTE_LANE = 4'b0000;
    endcase
  end

  // pointers, byte offset, pulse arbitration and flush tracking
  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      INCFIFO    <= 1'b0;
      DECFIFO    <= 1'b0;
      inc_pend   <= 1'b0;
      dec_pend   <= 1'b0;
      WRITE_PTR  <= '0;
      READ_PTR   <= '0;
      BO         <= 2'd0;
      flush_pend <= 1'b0;
      flush_wait <= 1'b0;
      FLUSHED    <= 1'b0;
      OVR        <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      INCFIFO  <= go_inc;
      DECFIFO  <= go_dec;
      inc_pend <= inc_req & ~go_inc;
      dec_pend <= dec_req & ~go_dec;
      if (inc_new)
        WRITE_PTR <= WRITE_PTR + PTR_ONE;
      if (dec_new)
        READ_PTR <= READ_PTR + PTR_ONE;
      if (side_acc)
        BO <= bo_nxt;
      else if (flush_go)
        BO <= 2'd0;
      flush_pend <= flush_req & ~flush_go;
      if (flush_inc)
        flush_wait <= 1'b1;
      else if (INCFIFO)
        flush_wait <= 1'b0;
      FLUSHED <= (flush_go & ~flush_inc)
               | (flush_wait & INCFIFO);
      OVR     <= OVR | ovr_set;
      dir_q   <= DMADIR;
    end
  end

endmodule
